// File: rtl/demux_64bit_1to8_buf_if.sv
// demux_64bit_1to8_buf_if: upstream and downstream handshake bundle for the 1-to-8 result demux
//   in_valid/in_ready/in_sel/in_data : one word from the ALU result path, steered by in_sel
//   out_valid/out_ready/out_data     : eight lanes, lane k at out_data[k*WIDTH +: WIDTH]
//   master = producer/consumer side, slave = the demux
interface demux_64bit_1to8_buf_if #(parameter int WIDTH = 64);
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [8*WIDTH-1:0] out_data;
  modport master (output in_valid, in_sel, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave (input in_valid, in_sel, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/demux_64bit_1to8_buf.sv
// demux_64bit_1to8_buf: buffered 1-to-8 demux, one holding register per lane with valid/ready
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears every lane
//   bus      : demux_64bit_1to8_buf_if.slave (upstream word in, eight lanes out)
//   xfer_cnt : accepted-word count, present only when DEMUX_STATS_EN is defined
module demux_64bit_1to8_buf #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  demux_64bit_1to8_buf_if.slave bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0] xfer_cnt
`endif
);
  logic [7:0]       valid_q, valid_d;
  logic [WIDTH-1:0] lane_q [8];
  logic [WIDTH-1:0] lane_d [8];
  logic             accept;
  // A lane can take a word when empty or when its current word leaves on this same edge.
  assign bus.in_ready = !valid_q[bus.in_sel] || bus.out_ready[bus.in_sel];
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      valid_d[k] = (accept && bus.in_sel == 3'(k)) || (valid_q[k] && !bus.out_ready[k]);
      lane_d[k] = (accept && bus.in_sel == 3'(k)) ? bus.in_data : lane_q[k];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < 8; k++) lane_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      lane_q <= lane_d;
    end
  end
  for (genvar g = 0; g < 8; g++) begin : g_out
    assign bus.out_data[g*WIDTH +: WIDTH] = lane_q[g];
  end
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= accept ? cnt_q + 16'd1 : cnt_q;
  end
  assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux_64bit_1to8_buf.sv
// tb_demux_64bit_1to8_buf: table vectors, directed corner sequences and random traffic against a lane model
module tb_demux_64bit_1to8_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux_64bit_1to8_buf_if #(.WIDTH(64)) bus ();
`ifdef DEMUX_STATS_EN
  logic [15:0] xfer_cnt;
`endif
  demux_64bit_1to8_buf #(.WIDTH(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DEMUX_STATS_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );
  int total = 0;
  int bad = 0;
  logic        m_valid [8];
  logic [63:0] m_data [8];
  logic [15:0] m_cnt;
  logic        last_rdy;
  typedef struct {
    logic [2:0]  sel;
    logic [63:0] data;
    logic        exp_rdy;
    logic [7:0]  exp_valid;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] m_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_valid[k];
    return v;
  endfunction
  function automatic logic m_rdy(input logic [2:0] s, input logic [7:0] r);
    return !m_valid[s] || r[s];
  endfunction
  task automatic m_clear();
    for (int k = 0; k < 8; k++) begin
      m_valid[k] = 1'b0;
      m_data[k] = '0;
    end
    m_cnt = '0;
  endtask
  task automatic check_outs(input string tag);
    chk({tag, ".valid"}, {56'd0, bus.out_valid}, {56'd0, m_vec()});
    for (int k = 0; k < 8; k++) chk($sformatf("%s.lane%0d", tag, k), bus.out_data[k*64 +: 64], m_data[k]);
`ifdef DEMUX_STATS_EN
    chk({tag, ".cnt"}, {48'd0, xfer_cnt}, {48'd0, m_cnt});
`endif
  endtask
  // One cycle: drive at negedge, check in_ready before the edge, check registered outputs after it.
  task automatic step(input logic v, input logic [2:0] s, input logic [63:0] d, input logic [7:0] r);
    logic acc;
    bus.in_valid = v;
    bus.in_sel = s;
    bus.in_data = d;
    bus.out_ready = r;
    #1;
    last_rdy = bus.in_ready;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, m_rdy(s, r)});
    acc = v && m_rdy(s, r);
    @(posedge clk);
    for (int k = 0; k < 8; k++) if (m_valid[k] && r[k]) m_valid[k] = 1'b0;
    if (acc) begin
      m_valid[s] = 1'b1;
      m_data[s] = d;
      m_cnt = m_cnt + 16'd1;
    end
    #1 check_outs("step");
    @(negedge clk);
  endtask
  // Assert reset between edges and confirm everything clears before the next edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    bus.out_ready = 8'h00;
    #1;
    chk("arst.valid", {56'd0, bus.out_valid}, 64'd0);
    chk("arst.data", {63'd0, |bus.out_data}, 64'd0);
    chk("arst.in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef DEMUX_STATS_EN
    chk("arst.cnt", {48'd0, xfer_cnt}, 64'd0);
`endif
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [3:0] nibs [8];
    logic [63:0] d;
    nibs = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
    for (int i = 0; i < 8; i++) begin
      tbl[i].sel = 3'(i);
      tbl[i].data = {16{nibs[i]}};
      tbl[i].exp_rdy = 1'b1;
      tbl[i].exp_valid = 8'((16'd2 << i) - 16'd1);
    end
    m_clear();
    bus.in_valid = 1'b0;
    bus.in_sel = '0;
    bus.in_data = '0;
    bus.out_ready = '0;
    #1;
    chk("rst.valid", {56'd0, bus.out_valid}, 64'd0);
    chk("rst.data", {63'd0, |bus.out_data}, 64'd0);
    chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].sel, tbl[i].data, 8'h00);
      chk($sformatf("sweep%0d.rdy", i), {63'd0, last_rdy}, {63'd0, tbl[i].exp_rdy});
      chk($sformatf("sweep%0d.valid", i), {56'd0, bus.out_valid}, {56'd0, tbl[i].exp_valid});
      chk($sformatf("sweep%0d.data", i), bus.out_data[i*64 +: 64], tbl[i].data);
    end
    step(1'b1, 3'd3, 64'h1234_5678_9ABC_DEF0, 8'h00);
    chk("stall.rdy", {63'd0, last_rdy}, 64'd0);
    chk("stall.hold", bus.out_data[3*64 +: 64], {16{4'hD}});
    step(1'b1, 3'd3, 64'h1234_5678_9ABC_DEF0, 8'h08);
    chk("stall.rel_rdy", {63'd0, last_rdy}, 64'd1);
    chk("stall.load", bus.out_data[3*64 +: 64], 64'h1234_5678_9ABC_DEF0);
    chk("stall.valid", {56'd0, bus.out_valid}, 64'hFF);
    step(1'b0, 3'd0, 64'd0, 8'hFF);
    chk("drain.valid", {56'd0, bus.out_valid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      d = {$urandom, $urandom};
      step(1'b1, 3'd5, d, 8'hFF);
      chk($sformatf("stream%0d.rdy", i), {63'd0, last_rdy}, 64'd1);
      chk($sformatf("stream%0d.valid", i), {56'd0, bus.out_valid}, 64'h20);
      chk($sformatf("stream%0d.data", i), bus.out_data[5*64 +: 64], d);
    end
    step(1'b0, 3'd0, 64'd0, 8'hFF);
    step(1'b1, 3'd0, 64'h0BAD_CAFE_0000_0001, 8'h00);
    step(1'b1, 3'd1, 64'h1111_0000_1111_0000, 8'h00);
    chk("indep.l1_rdy", {63'd0, last_rdy}, 64'd1);
    step(1'b1, 3'd2, 64'h2222_0000_2222_0000, 8'h00);
    chk("indep.l2_rdy", {63'd0, last_rdy}, 64'd1);
    chk("indep.l0_hold", bus.out_data[63:0], 64'h0BAD_CAFE_0000_0001);
    chk("indep.valid", {56'd0, bus.out_valid}, 64'h07);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 3'($urandom), {$urandom, $urandom}, 8'($urandom & $urandom));
    step(1'b0, 3'd0, 64'd0, 8'hFF);
    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), {$urandom, $urandom}, 8'h00);
    chk("prearst.valid", {56'd0, bus.out_valid}, 64'hFF);
    mid_reset();
    step(1'b1, 3'd4, 64'h4444_4444_0000_0004, 8'h00);
    chk("postrst.valid", {56'd0, bus.out_valid}, 64'h10);
`ifdef DEMUX_STATS_EN
    mid_reset();
    bus.in_valid = 1'b1;
    bus.in_sel = 3'd0;
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 65536; i++) begin
      bus.in_data = 64'(i);
      @(negedge clk);
    end
    m_valid[0] = 1'b1;
    m_data[0] = 64'd65535;
    chk("wrap.cnt", {48'd0, xfer_cnt}, 64'd0);
    step(1'b0, 3'd0, 64'd0, 8'hFF);
    step(1'b0, 3'd0, 64'd0, 8'hFF);
    chk("drain_only.cnt", {48'd0, xfer_cnt}, 64'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_64bit_1to8_buf.md
# demux_64bit_1to8_buf

Buffered 1-to-8 demultiplexer that routes a 64-bit ALU result to one of eight destinations selected by a 3-bit code, the inverse of the 8:1 result-select mux. Each destination has a one-entry holding register with a valid/ready handshake, so a stalled consumer blocks only its own lane. Sits between the ALU result path and the eight downstream consumers (writeback/forwarding lanes).

## Interface
- `WIDTH`, 64, data width per lane.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  one clock; reset is asynchronous and active-low.
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  word accepted this cycle when `in_valid && in_ready`.
- `in_sel`  input  3  destination lane 0..7 (000 = lane 0 ... 111 = lane 7).
- `in_data`  input  WIDTH  word to route.
- `out_valid`  output  8  bit k: lane k holds a word.
- `out_ready`  input  8  bit k: lane k consumer takes word.
- `out_data`  output  8*WIDTH  lane k at `[k*WIDTH +: WIDTH]`.
- `xfer_cnt`  output  16  accepted-word count (present only with `DEMUX_STATS_EN`).

## Operation
- Per lane k: state EMPTY (`out_valid[k]=0`) or FULL (`out_valid[k]=1`), data register `lane_q[k]`.
- `in_ready = !out_valid[in_sel] || out_ready[in_sel]`; combinational in `in_sel`, `out_valid`, `out_ready`; independent of `in_valid`.
- Accept (`in_valid && in_ready`): `lane_q[in_sel] <= in_data`, lane goes/stays FULL.
- Drain (`out_valid[k] && out_ready[k]`) without accept to k: lane k -> EMPTY; `lane_q[k]` retains old value.
- Simultaneous drain and accept on same lane: old word consumed, new word loaded, lane stays FULL (full throughput, one word/cycle).
- Accept to lane j and drains on any other lanes in the same cycle: all independent.
- Non-selected lanes never change data on accept.
- FULL lane with `out_ready[k]=0`: `out_data` lane k and `out_valid[k]` held stable.
- `in_sel` is don't-care when `in_valid=0`; `in_ready` still reflects the lane it addresses.
- No reordering within a lane; no ordering guarantee across lanes.

## Timing
- Reset (async assert, sync release on next `clk` edge after deassert): `out_valid=8'h00`, all `out_data=0`, `xfer_cnt=0`. `in_ready` reads 1 during reset (all lanes empty).
- Latency: word accepted at edge N appears on `out_data`/`out_valid` after edge N; consumable at edge N+1.
- Reset mid-operation: all buffered words discarded immediately; no partial state survives.
- Back-to-back accepts to the same lane stall if the consumer holds `out_ready` low: second word waits with `in_ready=0`.
- No combinational path from `in_data` to `out_data`; `out_*` are registered.

## Configuration
- `DEMUX_STATS_EN` defined: `xfer_cnt` port present; increments by 1 on every accept, wraps 16'hFFFF -> 16'h0000, cleared by reset, unaffected by drains.
- Undefined: `xfer_cnt` port and counter logic absent; all other behaviour identical.

## Test plan
- Reset then sweep: `in_sel` 0..7 with `in_data` = 64'hAAAA…, BBBB…, CCCC…, DDDD…, EEEE…, FFFF…, 1111…, 2222…, all `out_ready=0` -> each lane k FULL with its value one cycle after accept, `out_valid=8'hFF`, `in_ready=1` throughout.
- Stall: lane 3 FULL with 64'hDDDD…, `out_ready[3]=0`, present 64'h1234… to lane 3 -> `in_ready=0`, lane 3 holds DDDD…; raise `out_ready[3]` -> same edge consumes DDDD… and loads 1234…, `out_valid[3]` stays 1.
- Streaming: `out_ready=8'hFF`, 8 consecutive words to lane 5 -> `in_ready` constant 1, lane 5 outputs each word exactly one cycle after acceptance, other lanes stay EMPTY.
- Independence: lane 0 stalled FULL while words sent to lanes 1,2 -> accepted without stall; lane 0 data unchanged.
- Async reset with `out_valid=8'hFF` mid-clock -> `out_valid=8'h00`, `out_data=0` immediately, before next edge.
- With `DEMUX_STATS_EN`: preload via 65536 accepts -> `xfer_cnt` wraps to 0; drains alone leave count unchanged.
